// File: rtl/baccarat_pkg.sv
// ---------------------------------------------------------------------------
// baccarat_pkg
// Shared constants and types for the baccarat datapath: card rank codes,
// the width of a single card's score value, and the dealing FSM state type
// used by the hand score accumulator and the dealer FSM.
// No ports (package).
// ---------------------------------------------------------------------------
package baccarat_pkg;

    localparam int RANK_ACE   = 1;
    localparam int RANK_NINE  = 9;
    localparam int RANK_TEN   = 10;
    localparam int RANK_KING  = 13;

    // Wide enough for the largest face value (9).
    localparam int CARD_VAL_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DEALING = 2'd1,
        DONE    = 2'd2
    } deal_state_t;

endpackage

// File: rtl/hand_score_accumulator_card_value.sv
// ---------------------------------------------------------------------------
// card_value
// Combinational mapping from a card rank to its baccarat score value.
// Ranks ace..nine score their face value; rank 0, ten and the court cards
// (and any unused code) score 0.
// Ports:
//   rank   in   CARD_W       raw card rank
//   value  out  CARD_VAL_W   score contribution of the card
// ---------------------------------------------------------------------------
module card_value
    import baccarat_pkg::*;
#(
    parameter int CARD_W = 4
) (
    input  logic [CARD_W-1:0]     rank,
    output logic [CARD_VAL_W-1:0] value
);

    always_comb begin
        value = '0;
        if ((32'(rank) >= RANK_ACE) && (32'(rank) <= RANK_NINE)) begin
            value = CARD_VAL_W'(rank);
        end
    end

endmodule

// File: rtl/hand_score_accumulator.sv
// ---------------------------------------------------------------------------
// hand_score_accumulator
// Accepts one card per cycle over a valid/ready handshake and routes it to one
// of NUM_HANDS hands. Each hand keeps a running modulo-MOD score, a card count
// and a natural flag (exactly two cards scoring MOD-2 or MOD-1).
// Optional feature macro: CARD_LOG_EN adds the 'cards' output holding the raw
// ranks of every hand in slot order.
// Ports:
//   slow_clock  in   1                     clock, rising edge
//   reset       in   1                     synchronous, active-high
//   start       in   1                     clear all hands, enter DEALING
//   stand       in   1                     stop dealing, enter DONE
//   card_valid  in   1                     card offered this cycle
//   card_ready  out  1                     card can be accepted
//   card_rank   in   CARD_W                rank of offered card
//   card_hand   in   HAND_W                destination hand index
//   score       out  NUM_HANDS*SCORE_W     packed scores, hand 0 at LSBs
//   count       out  NUM_HANDS*CNT_W       packed card counts
//   natural     out  NUM_HANDS             per-hand natural flag
//   done        out  1                     FSM in DONE
//   err         out  1                     pulse: previous accepted card dropped
//   cards       out  NUM_HANDS*MAX_CARDS*CARD_W  (CARD_LOG_EN only) rank log
// ---------------------------------------------------------------------------
module hand_score_accumulator
    import baccarat_pkg::*;
#(
    parameter  int NUM_HANDS = 2,
    parameter  int MAX_CARDS = 3,
    parameter  int CARD_W    = 4,
    parameter  int MOD       = 10,
    localparam int SCORE_W   = $clog2(MOD),
    localparam int HAND_W    = $clog2(NUM_HANDS) + 1,
    localparam int CNT_W     = $clog2(MAX_CARDS + 1)
) (
    input  logic                           slow_clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stand,
    input  logic                           card_valid,
    output logic                           card_ready,
    input  logic [CARD_W-1:0]              card_rank,
    input  logic [HAND_W-1:0]              card_hand,
    output logic [NUM_HANDS*SCORE_W-1:0]   score,
    output logic [NUM_HANDS*CNT_W-1:0]     count,
    output logic [NUM_HANDS-1:0]           natural,
    output logic                           done,
    output logic                           err
`ifdef CARD_LOG_EN
    ,
    output logic [NUM_HANDS*MAX_CARDS*CARD_W-1:0] cards
`endif
);

    localparam logic [HAND_W-1:0]  HAND_LIMIT = HAND_W'(NUM_HANDS);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(MAX_CARDS);
    localparam logic [CNT_W-1:0]   CNT_TWO    = CNT_W'(2);
    localparam logic [SCORE_W:0]   MOD_WIDE   = (SCORE_W + 1)'(MOD);
    localparam logic [SCORE_W-1:0] NAT_LO     = SCORE_W'(MOD - 2);
    localparam logic [SCORE_W-1:0] NAT_HI     = SCORE_W'(MOD - 1);

    deal_state_t          state_q, state_d;
    logic [SCORE_W-1:0]   score_q   [NUM_HANDS];
    logic [SCORE_W-1:0]   score_d   [NUM_HANDS];
    logic [CNT_W-1:0]     count_q   [NUM_HANDS];
    logic [CNT_W-1:0]     count_d   [NUM_HANDS];
    logic [NUM_HANDS-1:0] natural_q, natural_d;
    logic                 err_q, err_d;

    logic [CARD_VAL_W-1:0] card_val;
    logic                  accept;
    logic                  hand_ok;
    logic                  drop;
    logic                  write_en;
    logic                  all_full;
    logic [SCORE_W-1:0]    tgt_score;
    logic [CNT_W-1:0]      tgt_count;
    logic [SCORE_W:0]      sum;
    logic [SCORE_W-1:0]    new_score;
    logic [CNT_W-1:0]      new_count;

    card_value #(
        .CARD_W (CARD_W)
    ) u_card_value (
        .rank  (card_rank),
        .value (card_val)
    );

    // Registered outputs plus the handshake ready. Ready deliberately ignores
    // card_hand so that a bad index is accepted and then flagged via err.
    always_comb begin
        score      = '0;
        count      = '0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            score[h*SCORE_W +: SCORE_W] = score_q[h];
            count[h*CNT_W +: CNT_W]     = count_q[h];
        end
        natural    = natural_q;
        done       = (state_q == DONE);
        err        = err_q;
        card_ready = (state_q == DEALING) && !start && !stand;
    end

    // Look up the addressed hand and form its candidate new score/count.
    always_comb begin
        hand_ok   = (card_hand < HAND_LIMIT);
        tgt_score = '0;
        tgt_count = '0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            if (card_hand == HAND_W'(h)) begin
                tgt_score = score_q[h];
                tgt_count = count_q[h];
            end
        end
        accept    = card_valid && card_ready;
        drop      = !hand_ok || (tgt_count == CNT_FULL);
        write_en  = accept && !drop;
        sum       = {1'b0, tgt_score} + (SCORE_W + 1)'(card_val);
        if (sum >= MOD_WIDE) begin
            new_score = SCORE_W'(sum - MOD_WIDE);
        end else begin
            new_score = SCORE_W'(sum);
        end
        new_count = tgt_count + CNT_W'(1);
    end

    // Per-hand state update; start clears everything regardless of state.
    // all_full looks at the post-update counts so the final card ends dealing.
    always_comb begin
        score_d   = score_q;
        count_d   = count_q;
        natural_d = natural_q;
        all_full  = 1'b1;
        if (start) begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                score_d[h] = '0;
                count_d[h] = '0;
            end
            natural_d = '0;
        end else if (write_en) begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                if (card_hand == HAND_W'(h)) begin
                    score_d[h]   = new_score;
                    count_d[h]   = new_count;
                    natural_d[h] = (new_count == CNT_TWO) &&
                                   ((new_score == NAT_LO) || (new_score == NAT_HI));
                end
            end
        end
        for (int h = 0; h < NUM_HANDS; h++) begin
            all_full = all_full && (count_d[h] == CNT_FULL);
        end
    end

    // Dealing FSM next state; start has priority over stand and cards.
    always_comb begin
        state_d = state_q;
        err_d   = accept && drop;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DEALING;
                end
            end
            DEALING: begin
                if (start) begin
                    state_d = DEALING;
                end else if (stand) begin
                    state_d = DONE;
                end else if (accept && all_full) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = DEALING;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_q   <= IDLE;
            for (int h = 0; h < NUM_HANDS; h++) begin
                score_q[h] <= '0;
                count_q[h] <= '0;
            end
            natural_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            count_q   <= count_d;
            natural_q <= natural_d;
            err_q     <= err_d;
        end
    end

`ifdef CARD_LOG_EN
    localparam int LOG_W = NUM_HANDS * MAX_CARDS * CARD_W;

    logic [LOG_W-1:0] cards_q, cards_d;

    // A card lands in the slot indexed by the hand's count before the accept.
    always_comb begin
        cards_d = cards_q;
        if (start) begin
            cards_d = '0;
        end else if (write_en) begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                for (int s = 0; s < MAX_CARDS; s++) begin
                    if ((card_hand == HAND_W'(h)) && (tgt_count == CNT_W'(s))) begin
                        cards_d[(h*MAX_CARDS + s)*CARD_W +: CARD_W] = card_rank;
                    end
                end
            end
        end
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            cards_q <= '0;
        end else begin
            cards_q <= cards_d;
        end
    end

    assign cards = cards_q;
`endif

endmodule
